mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Multi-cycle load/store controller between the CPU memory stage and a word-wide synchronous data RAM with no byte enables.
- Accepts one request at a time and checks alignment.
- Loads: extracts and extends byte/half/word from the read word.
- Sub-word stores: read-modify-write. Stalls the CPU via req_ready.
- Lane order is big-endian: byte offset 0 is bits 31:24; half offset 0 is bits 31:16.

Parameters:
ADDR_W, 11, word-address width driven to the RAM (mem_addr = req_addr[ADDR_W+1:2]).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present; sampled only while req_ready=1
req_write  input  1  1 = store, 0 = load
req_addr  input  32  physical byte address; bits [1:0] are the lane offset
req_size  input  2  access size: 00 = word, 01 = half, 10 = byte, 11 = illegal
req_bitext  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
req_ready  output  1  high only in IDLE; CPU stalls while low
rsp_valid  output  1  one-cycle pulse completing the accepted request
rsp_rdata  output  32  extended load data; 0 for stores and faults
rsp_fault  output  1  valid with rsp_valid; misaligned or illegal size
mem_en  output  1  RAM access strobe, one cycle per access
mem_we  output  1  RAM write enable, qualified by mem_en
mem_addr  output  ADDR_W  RAM word address
mem_wdata  output  32  RAM write word
mem_rdata  input  32  RAM read word, valid the cycle after mem_en=1 with mem_we=0

Behaviour:
- All outputs are registered except req_ready, which is decoded from state.
- Reset (any state, any cycle):
  - state goes to IDLE; req_ready=1.
  - rsp_valid, rsp_fault, mem_en and mem_we go to 0; rsp_rdata, mem_addr and mem_wdata go to 0.
  - An in-flight access is abandoned and no write is issued after reset.
- States: IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, RESP.
- IDLE, on req_valid (accept cycle T):
  - Latches addr, size, write, bitext and wdata.
  - Fault if size=11, or size=01 with addr[0]=1, or size=00 with addr[1:0]!=0.
  - Next state:
    - fault -> RESP
    - load -> RD_ISSUE
    - word store -> WR_ISSUE
    - byte/half store -> RD_ISSUE
- RD_ISSUE: mem_en=1, mem_we=0 -> RD_DATA.
- RD_DATA:
  - Load: registers the extended lane into the response data -> RESP.
  - Sub-word store: registers the merged word (read word with the addressed lane replaced by the low bits of wdata) -> WR_ISSUE.
- WR_ISSUE: mem_en=1, mem_we=1, mem_wdata = full word (word store) or merged word (sub-word store) -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_fault=1 only for a faulted request; rsp_rdata=0 unless a successful load.
  - -> IDLE.
- Latency from accept cycle T:
  - fault: rsp_valid at T+1
  - word store: WR at T+1, rsp at T+2
  - load: rsp at T+3
  - sub-word store: RD at T+1, WR at T+3, rsp at T+4
- Throughput: the next request is accepted no earlier than the cycle after rsp_valid.
- req_valid outside IDLE is ignored. Request inputs need not be held after acceptance.
- Extraction:
  - Byte: offset 0..3 selects bits [31:24], [23:16], [15:8], [7:0].
  - Half: offset 0 selects [31:16]; offset 2 selects [15:0].
  - Sign extension uses the selected lane's MSB.
- Faulted requests never assert mem_en.
- mem_en and mem_we are deasserted in every state other than RD_ISSUE and WR_ISSUE.
- mem_addr holds the latched word address from the cycle after accept until the next accept.

Test Plan:
- Load byte, addr=0x0000_0001, bitext=0, RAM word 0x12F4_5678 -> mem_en at T+1 with mem_addr=0, rsp at T+3, rsp_rdata=0xFFFF_FFF4, fault=0.
- Load half, addr=0x6, bitext=1, RAM word 0x0000_8001 -> mem_addr=1, rsp_rdata=0x0000_8001; repeat with bitext=0 -> 0xFFFF_8001.
- Store byte, addr=0x8 (offset 0), wdata=0x0000_00AB, RAM word 0x1122_3344:
  - RD at T+1, WR at T+3 with mem_wdata=0xAB22_3344, rsp at T+4, rsp_rdata=0.
  - Store half at addr=0xA, wdata=0xBEEF, same RAM word -> mem_wdata=0x1122_BEEF.
- Word store, addr=0xC, wdata=0xDEAD_BEEF -> single write at T+1 with mem_addr=3; rsp at T+2; req_ready low T+1..T+2.
- Misaligned half addr=0x3, misaligned word addr=0x2, and size=11 -> rsp_valid and rsp_fault at T+1 in each case, mem_en never asserted.
- rst asserted in RD_DATA of a sub-word store -> next cycle IDLE, all outputs 0, no write ever issued; back-to-back requests with req_valid held high are each accepted exactly once.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between the CPU memory stage and a word-wide
// synchronous RAM: alignment check, lane extract/extend on loads, read-modify-write for sub-word stores.
module mem_access_sequencer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_bitext,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_ISSUE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t              state_q;
    logic [1:0]          off_q;
    logic [1:0]          size_q;
    logic                write_q;
    logic                bitext_q;
    logic [15:0]         wdata_q;
    logic                rsp_valid_q;
    logic                rsp_fault_q;
    logic [31:0]         rsp_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic                fault_d;
    logic [31:0]         ext_d;
    logic [31:0]         merge_d;
    logic                unused_addr_hi;

    // Upper address bits lie outside the RAM window and are deliberately dropped.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Big-endian lanes: offset 0 is the most significant byte/half.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] size, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            SZ_BYTE: r = {{24{~zext & b[7]}}, b};
            SZ_HALF: r = {{16{~zext & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    r = {wd[7:0], w[23:0]};
                2'd1:    r = {w[31:24], wd[7:0], w[15:0]};
                2'd2:    r = {w[31:16], wd[7:0], w[7:0]};
                default: r = {w[31:8], wd[7:0]};
            endcase
        end else if (size == SZ_HALF) begin
            r = off[1] ? {w[31:16], wd} : {wd, w[15:0]};
        end
        return r;
    endfunction

    always_comb begin
        fault_d = 1'b0;
        case (req_size)
            SZ_WORD: fault_d = |req_addr[1:0];
            SZ_HALF: fault_d = req_addr[0];
            SZ_BYTE: fault_d = 1'b0;
            default: fault_d = 1'b1;
        endcase
    end

    assign ext_d   = extract(mem_rdata, off_q, size_q, bitext_q);
    assign merge_d = merge(mem_rdata, off_q, size_q, wdata_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            write_q     <= 1'b0;
            bitext_q    <= 1'b0;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        off_q       <= req_addr[1:0];
                        size_q      <= req_size;
                        write_q     <= req_write;
                        bitext_q    <= req_bitext;
                        wdata_q     <= req_wdata[15:0];
                        mem_addr_q  <= req_addr[ADDR_W+1:2];
                        rsp_rdata_q <= 32'h0;
                        if (fault_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            state_q     <= RESP;
                        end else if (req_write && req_size == SZ_WORD) begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata;
                            state_q     <= WR_ISSUE;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            mem_en_q <= 1'b1;
                            mem_we_q <= 1'b0;
                            state_q  <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    mem_en_q <= 1'b0;
                    state_q  <= RD_DATA;
                end
                RD_DATA: begin
                    if (write_q) begin
                        mem_wdata_q <= merge_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        state_q     <= WR_ISSUE;
                    end else begin
                        rsp_rdata_q <= ext_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WR_ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    state_q     <= IDLE;
                end
                default: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with a behavioural synchronous RAM.
module tb_mem_access_sequencer;

    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_bitext;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_bitext(req_bitext), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc_cyc;
        int          rsp_cyc;
        int          wr_cyc;
        int          nmem;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_mem = 0;
    logic [31:0] ram [0:2**ADDR_W-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic zx);
        logic [31:0] v;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * (3 - int'(off));
            v = (w >> sh) & 32'h0000_00FF;
            if (!zx && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            sh = 16 * (1 - int'(off[1]));
            v = (w >> sh) & 32'h0000_FFFF;
            if (!zx && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Response / RAM-port monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() != 0 && cyc > exp_q[0].acc_cyc)
                check("ready_low", 32'(req_ready), 32'd0);
            if (mem_we) check("we_qual", 32'(mem_en), 32'd1);
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    check("unexp_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    n_mem++;
                    check("mem_addr", 32'(mem_addr), exp_q[0].addr);
                    if (mem_we) begin
                        check("wr_cyc", cyc, exp_q[0].wr_cyc);
                        check("wr_data", mem_wdata, exp_q[0].wdata);
                    end
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexp_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_cyc", cyc, e.rsp_cyc);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                    check("mem_accesses", n_mem, e.nmem);
                    n_mem = 0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic bx, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eflt, input int lat,
                         input int nmem, input int wlat, input logic [31:0] ewd,
                         input bit hold);
        exp_t e;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = sz;
        req_bitext = bx;
        req_wdata  = wd;
        e.rdata   = erd;
        e.fault   = eflt;
        e.acc_cyc = cyc;
        e.rsp_cyc = cyc + lat;
        e.wr_cyc  = (wlat < 0) ? -1 : cyc + wlat;
        e.nmem    = nmem;
        e.addr    = {21'h0, addr[ADDR_W+1:2]};
        e.wdata   = ewd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            n_mem = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] w8;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_size = 2'b00; req_bitext = 1'b0; req_wdata = 32'h0;
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 32'h0;
        ram[0] = 32'h12F4_5678;
        ram[1] = 32'h0000_8001;
        ram[2] = 32'h1122_3344;
        ram[4] = 32'h0BAD_F00D;
        ram[8] = 32'h807F_C301;
        w8 = ram[8];
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Loads
        issue(0, 32'h1, 2'b10, 0, 32'h0, 32'hFFFF_FFF4, 0, 3, 1, -1, 32'h0, 0); wait_idle();
        issue(0, 32'h6, 2'b01, 1, 32'h0, 32'h0000_8001, 0, 3, 1, -1, 32'h0, 0); wait_idle();
        issue(0, 32'h6, 2'b01, 0, 32'h0, 32'hFFFF_8001, 0, 3, 1, -1, 32'h0, 0); wait_idle();
        for (int off = 0; off < 4; off++) begin
            for (int zx = 0; zx < 2; zx++) begin
                issue(0, 32'h20 + off, 2'b10, zx[0], 32'h0, ld_model(w8, off[1:0], 2'b10, zx[0]),
                      0, 3, 1, -1, 32'h0, 0);
                wait_idle();
                if (off[0] == 0) begin
                    issue(0, 32'h20 + off, 2'b01, zx[0], 32'h0, ld_model(w8, off[1:0], 2'b01, zx[0]),
                          0, 3, 1, -1, 32'h0, 0);
                    wait_idle();
                end
            end
        end

        // Sub-word and word stores
        issue(1, 32'h8, 2'b10, 0, 32'h0000_00AB, 32'h0, 0, 4, 2, 3, 32'hAB22_3344, 0); wait_idle();
        issue(1, 32'h8, 2'b00, 0, 32'h1122_3344, 32'h0, 0, 2, 1, 1, 32'h1122_3344, 0); wait_idle();
        issue(1, 32'hA, 2'b01, 0, 32'h0000_BEEF, 32'h0, 0, 4, 2, 3, 32'h1122_BEEF, 0); wait_idle();
        issue(1, 32'hC, 2'b00, 0, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 1, 32'hDEAD_BEEF, 0); wait_idle();
        issue(0, 32'hC, 2'b00, 0, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, -1, 32'h0, 0); wait_idle();
        issue(1, 32'h23, 2'b10, 0, 32'hFFFF_FF5A, 32'h0, 0, 4, 2, 3, 32'h807F_C35A, 0); wait_idle();

        // Faults never touch the RAM
        issue(0, 32'h3, 2'b01, 0, 32'h0, 32'h0, 1, 1, 0, -1, 32'h0, 0); wait_idle();
        issue(0, 32'h2, 2'b00, 0, 32'h0, 32'h0, 1, 1, 0, -1, 32'h0, 0); wait_idle();
        issue(0, 32'h0, 2'b11, 0, 32'h0, 32'h0, 1, 1, 0, -1, 32'h0, 0); wait_idle();
        issue(1, 32'h5, 2'b00, 0, 32'h1234_5678, 32'h0, 1, 1, 0, -1, 32'h0, 0); wait_idle();

        // Reset while a sub-word store sits in RD_DATA
        issue(1, 32'h10, 2'b10, 0, 32'h0000_0055, 32'h0, 0, 4, 2, 3, 32'h55AD_F00D, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        n_mem = 0;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_write_after_rst", ram[4], 32'h0BAD_F00D);

        // Back-to-back with req_valid held high
        issue(0, 32'h0, 2'b00, 0, 32'h0, 32'h12F4_5678, 0, 3, 1, -1, 32'h0, 1);
        issue(1, 32'h40, 2'b00, 0, 32'h0102_0304, 32'h0, 0, 2, 1, 1, 32'h0102_0304, 1);
        issue(0, 32'h41, 2'b10, 1, 32'h0, 32'h0000_0002, 0, 3, 1, -1, 32'h0, 0);
        wait_idle();
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
